// File: rtl/pbch_re_demux_ctrl.sv
// pbch_re_demux_ctrl
// Routes the PBCH resource elements of one SSB from the FFT output stream.
// DMRS REs go to the channel-estimation path. Data REs go to the
// serial-to-parallel packer in groups of 3. All other REs are dropped.
// Optional build macro PBCH_RE_CNT_EN adds per-SSB data/DMRS RE counters.
module pbch_re_demux_ctrl #(
  parameter int SERIAL_WIDTH = 32,
  parameter int NUM_SC       = 240,
  parameter int EDGE_SC      = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              cell_id_mod4,
  input  logic                    sym_start,
  input  logic                    fft_valid,
  input  logic [SERIAL_WIDTH-1:0] fft_data,
  output logic [SERIAL_WIDTH-1:0] s2p_serial,
  output logic                    s2p_in_valid,
  output logic [1:0]              s2p_parallel_mode,
  output logic [SERIAL_WIDTH-1:0] dmrs_data,
  output logic                    dmrs_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    sym_err
`ifdef PBCH_RE_CNT_EN
  ,
  output logic [8:0]              data_re_cnt,
  output logic [7:0]              dmrs_re_cnt
`endif
);

  localparam int SC_W = $clog2(NUM_SC);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYM,
    RUN,
    DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [1:0]              v, v_nxt;
  logic [SC_W-1:0]         sc_cnt, sc_nxt;
  logic [1:0]              sym_cnt, sym_nxt;
  logic [SERIAL_WIDTH-1:0] s2p_serial_nxt, dmrs_data_nxt;
  logic                    s2p_valid_nxt, dmrs_valid_nxt;
  logic                    busy_nxt, done_nxt, err_nxt;
  logic [1:0]              mode_nxt;
  logic                    is_pbch, is_dmrs, frame_bad;

  // Classify the current RE position: which symbols/subcarriers carry PBCH,
  // and whether it lands on the DMRS comb selected by v.
  always_comb begin
    is_pbch = 1'b0;
    case (sym_cnt)
      2'd1, 2'd3: is_pbch = 1'b1;
      2'd2:       is_pbch = (sc_cnt < SC_W'(EDGE_SC)) ||
                            (sc_cnt >= SC_W'(NUM_SC - EDGE_SC));
      default:    is_pbch = 1'b0;
    endcase
    is_dmrs   = (sc_cnt[1:0] == v);
    frame_bad = sym_start ? (sc_cnt != '0) : (sc_cnt == '0);
  end

  // Next-state and next-output logic for the SSB sequencing FSM.
  always_comb begin
    state_nxt      = state;
    v_nxt          = v;
    sc_nxt         = sc_cnt;
    sym_nxt        = sym_cnt;
    s2p_serial_nxt = s2p_serial;
    dmrs_data_nxt  = dmrs_data;
    s2p_valid_nxt  = 1'b0;
    dmrs_valid_nxt = 1'b0;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    err_nxt        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          v_nxt     = cell_id_mod4;
          busy_nxt  = 1'b1;
          sc_nxt    = '0;
          sym_nxt   = 2'd0;
          state_nxt = WAIT_SYM;
        end
      end
      WAIT_SYM: begin
        // The aligning RE is sc 0 of the PSS symbol, which carries no PBCH.
        if (fft_valid && sym_start) begin
          sym_nxt   = 2'd0;
          sc_nxt    = SC_W'(1);
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (fft_valid) begin
          if (frame_bad) begin
            err_nxt   = 1'b1;
            sym_nxt   = 2'd0;
            sc_nxt    = '0;
            state_nxt = WAIT_SYM;
          end else begin
            if (is_pbch) begin
              if (is_dmrs) begin
                dmrs_valid_nxt = 1'b1;
                dmrs_data_nxt  = fft_data;
              end else begin
                s2p_valid_nxt  = 1'b1;
                s2p_serial_nxt = fft_data;
              end
            end
            if (sc_cnt == SC_W'(NUM_SC - 1)) begin
              sc_nxt  = '0;
              sym_nxt = sym_cnt + 2'd1;
              if (sym_cnt == 2'd3) begin
                state_nxt = DONE;
              end
            end else begin
              sc_nxt = sc_cnt + SC_W'(1);
            end
          end
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        sc_nxt    = '0;
        sym_nxt   = 2'd0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
    mode_nxt = busy_nxt ? 2'd3 : 2'd0;
  end

  // State, position counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      v                 <= 2'd0;
      sc_cnt            <= '0;
      sym_cnt           <= 2'd0;
      s2p_serial        <= '0;
      s2p_in_valid      <= 1'b0;
      s2p_parallel_mode <= 2'd0;
      dmrs_data         <= '0;
      dmrs_valid        <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      sym_err           <= 1'b0;
    end else begin
      state             <= state_nxt;
      v                 <= v_nxt;
      sc_cnt            <= sc_nxt;
      sym_cnt           <= sym_nxt;
      s2p_serial        <= s2p_serial_nxt;
      s2p_in_valid      <= s2p_valid_nxt;
      s2p_parallel_mode <= mode_nxt;
      dmrs_data         <= dmrs_data_nxt;
      dmrs_valid        <= dmrs_valid_nxt;
      busy              <= busy_nxt;
      done              <= done_nxt;
      sym_err           <= err_nxt;
    end
  end

`ifdef PBCH_RE_CNT_EN
  // Per-SSB RE counters: cleared when an SSB is armed or restarted after a
  // framing error, held after done until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_re_cnt <= '0;
      dmrs_re_cnt <= '0;
    end else if ((state == IDLE && start) || sym_err) begin
      data_re_cnt <= '0;
      dmrs_re_cnt <= '0;
    end else begin
      if (s2p_in_valid) data_re_cnt <= data_re_cnt + 9'd1;
      if (dmrs_valid)   dmrs_re_cnt <= dmrs_re_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pbch_re_demux_ctrl.sv
// tb_pbch_re_demux_ctrl
// Drives SSB RE streams (directed and randomized) into pbch_re_demux_ctrl and
// compares every cycle against a position-based reference model of the grid.
module tb_pbch_re_demux_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  cell_id_mod4 = 2'd0;
  logic        sym_start = 1'b0;
  logic        fft_valid = 1'b0;
  logic [31:0] fft_data = 32'd0;
  logic [31:0] s2p_serial, dmrs_data;
  logic        s2p_in_valid, dmrs_valid, busy, done, sym_err;
  logic [1:0]  s2p_parallel_mode;
`ifdef PBCH_RE_CNT_EN
  logic [8:0]  data_re_cnt;
  logic [7:0]  dmrs_re_cnt;
`endif

  pbch_re_demux_ctrl dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cell_id_mod4(cell_id_mod4),
    .sym_start(sym_start),
    .fft_valid(fft_valid),
    .fft_data(fft_data),
    .s2p_serial(s2p_serial),
    .s2p_in_valid(s2p_in_valid),
    .s2p_parallel_mode(s2p_parallel_mode),
    .dmrs_data(dmrs_data),
    .dmrs_valid(dmrs_valid),
    .busy(busy),
    .done(done),
    .sym_err(sym_err)
`ifdef PBCH_RE_CNT_EN
    ,
    .data_re_cnt(data_re_cnt),
    .dmrs_re_cnt(dmrs_re_cnt)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: position inside the 960-RE grid, -1 while waiting.
  bit          m_busy, m_finish;
  int          m_pos, m_v;
  bit          e_s2p_valid, e_dmrs_valid, e_done, e_err, e_busy;
  logic [31:0] e_s2p_data, e_dmrs_data;
  logic [1:0]  e_mode;

  // Observed statistics for the current SSB.
  int          n_data, n_dmrs, n_err;
  logic [31:0] first_data, first_dmrs, first_sym2_dmrs;
  bit          seen_sym2_dmrs;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void modelReset();
    m_busy = 0; m_finish = 0; m_pos = -1; m_v = 0;
    e_s2p_valid = 0; e_dmrs_valid = 0; e_done = 0; e_err = 0; e_busy = 0;
    e_s2p_data = '0; e_dmrs_data = '0; e_mode = 2'd0;
  endfunction

  function automatic void modelStep(input bit st, input int cid, input bit ss,
                                    input bit fv, input logic [31:0] d);
    int  sc, sym;
    bit  pbch;
    e_s2p_valid = 0; e_dmrs_valid = 0; e_done = 0; e_err = 0;
    if (m_finish) begin
      e_done = 1; m_busy = 0; m_finish = 0;
    end else if (!m_busy) begin
      if (st) begin m_busy = 1; m_v = cid; m_pos = -1; end
    end else if (fv) begin
      if (m_pos < 0) begin
        if (ss) m_pos = 1;
      end else begin
        sc  = m_pos % 240;
        sym = m_pos / 240;
        if (ss != (sc == 0)) begin
          e_err = 1; m_pos = -1;
        end else begin
          pbch = (sym == 1) || (sym == 3) || (sym == 2 && (sc < 48 || sc >= 192));
          if (pbch) begin
            if (sc % 4 == m_v) begin e_dmrs_valid = 1; e_dmrs_data = d; end
            else begin e_s2p_valid = 1; e_s2p_data = d; end
          end
          m_pos++;
          if (m_pos == 960) m_finish = 1;
        end
      end
    end
    e_busy = m_busy;
    e_mode = m_busy ? 2'd3 : 2'd0;
  endfunction

  task automatic applyStimulus(input bit st, input int cid, input bit ss,
                               input bit fv, input logic [31:0] d);
    start = st; cell_id_mod4 = 2'(cid); sym_start = ss; fft_valid = fv; fft_data = d;
    modelStep(st, cid, ss, fv, d);
    @(posedge clk);
    #1;
    checkOutput("s2p_valid", 32'(s2p_in_valid), 32'(e_s2p_valid));
    checkOutput("dmrs_valid", 32'(dmrs_valid), 32'(e_dmrs_valid));
    checkOutput("s2p_serial", s2p_serial, e_s2p_data);
    checkOutput("dmrs_data", dmrs_data, e_dmrs_data);
    checkOutput("busy", 32'(busy), 32'(e_busy));
    checkOutput("done", 32'(done), 32'(e_done));
    checkOutput("sym_err", 32'(sym_err), 32'(e_err));
    checkOutput("mode", 32'(s2p_parallel_mode), 32'(e_mode));
    if (s2p_in_valid) begin
      if (n_data == 0) first_data = s2p_serial;
      n_data++;
    end
    if (dmrs_valid) begin
      if (n_dmrs == 0) first_dmrs = dmrs_data;
      if (!seen_sym2_dmrs && dmrs_data[15:0] >= 16'd480) begin
        first_sym2_dmrs = dmrs_data; seen_sym2_dmrs = 1;
      end
      n_dmrs++;
    end
    if (sym_err) n_err++;
  endtask

  task automatic clearStats();
    n_data = 0; n_dmrs = 0; first_data = '0; first_dmrs = '0;
    first_sym2_dmrs = '0; seen_sym2_dmrs = 0;
  endtask

  // gap_mode: 0 none, 1 alternate, 2 random. err_at: RE index where sym_start
  // framing is broken once (-1 none). stop_at: return early at that RE (-1 none).
  task automatic runSsb(input int v, input int gap_mode, input int err_at,
                        input int salt, input int stop_at);
    int idx;
    bit ph, err_done, ss;
    clearStats();
    n_err = 0;
    ph = 0; err_done = 0;
    repeat (2) applyStimulus(0, 0, $urandom_range(1), 1, $urandom);
    applyStimulus(1, v, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    idx = 0;
    while (idx < 960) begin
      if (stop_at >= 0 && idx == stop_at) return;
      if ((gap_mode == 1 && ph) || (gap_mode == 2 && $urandom_range(3) == 0)) begin
        ph = 0;
        applyStimulus(gap_mode == 2 && $urandom_range(15) == 0, $urandom_range(3),
                      $urandom_range(1), 0, $urandom);
        continue;
      end
      ph = 1;
      ss = (idx % 240 == 0);
      if (!err_done && idx == err_at) begin
        applyStimulus(0, 0, !ss, 1, (salt << 16) | idx);
        checkOutput("sym_err_pulse", 32'(sym_err), 32'd1);
        err_done = 1;
        idx = 0;
        clearStats();
        continue;
      end
      applyStimulus(gap_mode == 2 && $urandom_range(31) == 0, $urandom_range(3),
                    ss, 1, (salt << 16) | idx);
      idx++;
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("done_after_last", 32'(done), 32'd1);
    checkOutput("data_total", 32'(n_data), 32'd432);
    checkOutput("dmrs_total", 32'(n_dmrs), 32'd144);
    checkOutput("err_count", 32'(n_err), (err_at >= 0) ? 32'd1 : 32'd0);
`ifdef PBCH_RE_CNT_EN
    checkOutput("data_re_cnt", 32'(data_re_cnt), 32'd432);
    checkOutput("dmrs_re_cnt", 32'(dmrs_re_cnt), 32'd144);
`endif
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("busy_cleared", 32'(busy), 32'd0);
  endtask

  // Main sequence: reset, directed SSBs, randomized SSBs, mid-SSB reset.
  initial begin
    modelReset();
    clearStats();
    n_err = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_s2p_valid", 32'(s2p_in_valid), 32'd0);
    checkOutput("reset_dmrs_valid", 32'(dmrs_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_mode", 32'(s2p_parallel_mode), 32'd0);
    checkOutput("reset_s2p_serial", s2p_serial, 32'd0);
    rst = 1'b0;

    $display("[TB] clean SSB v=0");
    runSsb(0, 0, -1, 0, -1);
    checkOutput("v0_first_dmrs", first_dmrs, 32'd240);
    checkOutput("v0_first_data", first_data, 32'd241);

    $display("[TB] clean SSB v=3");
    runSsb(3, 0, -1, 0, -1);
    checkOutput("v3_first_dmrs", first_dmrs, 32'd243);
    checkOutput("v3_first_sym2_dmrs", first_sym2_dmrs, 32'd483);

    $display("[TB] half-rate SSB v=1");
    runSsb(1, 1, -1, 0, -1);
    checkOutput("half_first_dmrs", first_dmrs, 32'd241);

    $display("[TB] framing error at sym 1 sc 100");
    runSsb(2, 0, 340, 0, -1);

    $display("[TB] randomized SSBs");
    for (int k = 0; k < 4; k++) begin
      int e;
      e = ($urandom_range(1) == 0) ? -1 : 240 + $urandom_range(719);
      runSsb($urandom_range(3), 2, e, 1 + k, -1);
    end

    $display("[TB] reset in sym 3");
    runSsb(0, 0, -1, 0, 800);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst_s2p_valid", 32'(s2p_in_valid), 32'd0);
    checkOutput("rst_dmrs_valid", 32'(dmrs_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mode", 32'(s2p_parallel_mode), 32'd0);
    checkOutput("rst_s2p_serial", s2p_serial, 32'd0);
    checkOutput("rst_dmrs_data", dmrs_data, 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearStats();
    for (int i = 0; i < 300; i++) applyStimulus(0, 0, (i % 240 == 0), 1, i);
    checkOutput("post_rst_no_data", 32'(n_data + n_dmrs), 32'd0);
    runSsb(0, 0, -1, 0, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
